// File: rtl/pipe_chain.sv
// N-stage valid/allowin/ready_go pipeline with indexed younger-prefix flush and per-stage taps.
// Optional retire/stall counters are built only when PIPE_STAT_EN is defined.
module pipe_chain #(
  parameter int STAGES = 5,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(STAGES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_allowin,
  input  logic [STAGES-1:0]          ready_go,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_allowin,
  input  logic                       flush_valid,
  input  logic [IDX_W-1:0]           flush_idx,
  output logic [STAGES-1:0]          stage_valid,
  output logic [STAGES*DATA_W-1:0]   stage_data,
  output logic [31:0]                stat_retire,
  output logic [31:0]                stat_stall
);

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
  logic [STAGES:0]               allowin;
  logic [STAGES-1:0]             to_next;
  logic [STAGES-1:0]             kill;
  logic [STAGES-1:0]             src_valid;
  logic [STAGES-1:0][DATA_W-1:0] src_data;

  // Backpressure ripples from the consumer down to stage 0 in one process.
  always_comb begin
    allowin         = '0;
    allowin[STAGES] = out_allowin;
    for (int i = STAGES - 1; i >= 0; i--) begin
      allowin[i] = !valid_q[i] || (ready_go[i] && allowin[i+1]);
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    assign to_next[gi] = valid_q[gi] && ready_go[gi];
    assign kill[gi]    = flush_valid && (int'(flush_idx) >= gi);
    if (gi == 0) begin : g_head
      assign src_valid[gi] = in_valid && !flush_valid;
      assign src_data[gi]  = in_data;
    end else begin : g_body
      // A killed stage never hands its payload to the stage above it.
      assign src_valid[gi] = to_next[gi-1] && !kill[gi-1];
      assign src_data[gi]  = data_q[gi-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < STAGES; i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
      end else if (allowin[i]) begin
        valid_d[i] = src_valid[i];
        if (src_valid[i]) begin
          data_d[i] = src_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_allowin  = allowin[0] && !flush_valid;
  assign out_valid   = to_next[STAGES-1] && !kill[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = valid_q;
  assign stage_data  = data_q;

`ifdef PIPE_STAT_EN
  logic [31:0] retire_q, retire_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    retire_d = retire_q + {31'b0, (out_valid && out_allowin)};
    stall_d  = stall_q + {31'b0, (in_valid && !in_allowin)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      retire_q <= retire_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_retire = retire_q;
  assign stat_stall  = stall_q;
`else
  assign stat_retire = 32'd0;
  assign stat_stall  = 32'd0;
`endif

endmodule
